// File: rtl/nes_clk_pkg.sv
// rtl/nes_clk_pkg.sv - shared widths, default divide ratios and key level type
package nes_clk_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int CPU_DIV   = 12;
  localparam int PPU_DIV   = 4;
  localparam int VGA_DIV   = 2;

  // ch0 (CPU) occupies the least significant slice
  localparam logic [3*DEF_CNT_W-1:0] DEF_DIV_INIT =
    {DEF_CNT_W'(VGA_DIV), DEF_CNT_W'(PPU_DIV), DEF_CNT_W'(CPU_DIV)};

  typedef enum logic {
    KEY_PRESSED  = 1'b0,
    KEY_RELEASED = 1'b1
  } key_lvl_e;

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one programmable divide channel producing a clock enable and square wave
module clk_div_ch #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sys_rst_n,
  input  logic             i_tick,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_ce,
  output logic             o_sq,
  output logic             o_fired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_ce;
  logic             r_sq;
  logic             r_fired;
  logic [CNT_W-1:0] w_div_eff;
  logic [CNT_W-1:0] w_load;
  logic             w_wrap;

  // a zero ratio behaves as divide-by-one
  assign w_div_eff = (r_active == '0) ? CNT_W'(1) : r_active;
  assign w_wrap    = i_tick && (r_cnt == (w_div_eff - CNT_W'(1)));
  assign w_load    = i_cfg_we ? i_cfg_div : r_shadow;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt    <= '0;
      r_active <= DIV_RST;
      r_shadow <= DIV_RST;
      r_ce     <= 1'b0;
      r_sq     <= 1'b0;
      r_fired  <= 1'b0;
    end else begin
      if (i_cfg_we) begin
        r_shadow <= i_cfg_div;
      end
      if (!i_sys_rst_n) begin
        r_cnt    <= '0;
        r_active <= w_load;
        r_ce     <= 1'b0;
        r_sq     <= 1'b0;
        r_fired  <= 1'b0;
      end else begin
        r_ce <= w_wrap;
        if (w_wrap) begin
          r_cnt    <= '0;
          r_active <= w_load;
          r_sq     <= ~r_sq;
          r_fired  <= 1'b1;
        end else if (i_tick) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_ce    = r_ce;
  assign o_sq    = r_sq;
  assign o_fired = r_fired;

endmodule

// File: rtl/nes_clk_enable_gen.sv
// rtl/nes_clk_enable_gen.sv - NES clock-enable channels with debounced, stretched system reset
module nes_clk_enable_gen
  import nes_clk_pkg::*;
#(
  parameter int                        NUM_CH      = 3,
  parameter int                        CNT_W       = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT    = DEF_DIV_INIT,
  parameter int                        DEB_CYC     = 16,
  parameter int                        RST_STRETCH = 32,
  localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              run,
  input  logic              step,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic              sys_reset_n_o,
  output logic              locked_o
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int STR_W = $clog2(RST_STRETCH + 1);

  logic [1:0]        r_key_sync;
  key_lvl_e          r_deb;
  key_lvl_e          w_deb_next;
  key_lvl_e          w_sample;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [DEB_W-1:0]  w_deb_cnt_next;
  logic [STR_W-1:0]  r_stretch;
  logic              r_sys_rst_n;
  logic              w_tick;
  logic [NUM_CH-1:0] w_cfg_hit;
  logic [NUM_CH-1:0] w_fired;

  assign w_sample = key_lvl_e'(r_key_sync[1]);

  // the count tracks consecutive samples disagreeing with the accepted level
  always_comb begin
    w_deb_next     = r_deb;
    w_deb_cnt_next = '0;
    if (w_sample != r_deb) begin
      if (r_deb_cnt == DEB_W'(DEB_CYC - 1)) begin
        w_deb_next = w_sample;
      end else begin
        w_deb_cnt_next = r_deb_cnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key_sync <= '0;
      r_deb      <= KEY_PRESSED;
      r_deb_cnt  <= '0;
    end else begin
      r_key_sync <= {r_key_sync[0], key_rst_n};
      r_deb      <= w_deb_next;
      r_deb_cnt  <= w_deb_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stretch   <= STR_W'(RST_STRETCH);
      r_sys_rst_n <= 1'b0;
    end else if (w_deb_next == KEY_PRESSED) begin
      r_stretch   <= STR_W'(RST_STRETCH);
      r_sys_rst_n <= 1'b0;
    end else if (r_stretch != '0) begin
      r_stretch <= r_stretch - STR_W'(1);
    end else begin
      r_sys_rst_n <= 1'b1;
    end
  end

  assign w_tick = run | step;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_cfg_hit[g] = cfg_we && (int'(cfg_ch) == g);

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_sys_rst_n (r_sys_rst_n),
      .i_tick      (w_tick),
      .i_cfg_we    (w_cfg_hit[g]),
      .i_cfg_div   (cfg_div),
      .o_ce        (ce_o[g]),
      .o_sq        (sq_o[g]),
      .o_fired     (w_fired[g])
    );
  end

  assign sys_reset_n_o = r_sys_rst_n;
  assign locked_o      = r_sys_rst_n & (&w_fired);

endmodule

// File: tb/tb_nes_clk_enable_gen.sv
// tb/tb_nes_clk_enable_gen.sv - randomized and directed checks against a behavioural model
module tb_nes_clk_enable_gen;

  localparam int DEB_CYC     = 16;
  localparam int RST_STRETCH = 32;
  localparam int REL_LAT     = 2 + DEB_CYC + RST_STRETCH;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_rst_n = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic [2:0] ce_o;
  logic [2:0] sq_o;
  logic       sys_reset_n_o;
  logic       locked_o;

  int n_chk = 0;
  int n_bad = 0;

  nes_clk_enable_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_rst_n     (key_rst_n),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_div       (cfg_div),
    .run           (run),
    .step          (step),
    .ce_o          (ce_o),
    .sq_o          (sq_o),
    .sys_reset_n_o (sys_reset_n_o),
    .locked_o      (locked_o)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int       divs [3] = '{12, 4, 2};
  int       m_s0, m_s1, m_deb, m_rel;
  int       hist [$];
  bit       m_sys, m_lock;
  int       m_pos [3];
  int       m_per [3];
  int       m_nxt [3];
  bit [2:0] m_ce, m_sq, m_fired;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model_update();
    int  samp;
    bit  sys_old, all_diff, wr;
    if (!reset_n) begin
      m_s0 = 0; m_s1 = 0; hist.delete(); m_deb = 0; m_rel = 0; m_sys = 0;
      for (int c = 0; c < 3; c++) begin
        m_pos[c] = 0; m_per[c] = divs[c]; m_nxt[c] = divs[c];
      end
      m_ce = '0; m_sq = '0; m_fired = '0; m_lock = 0;
      return;
    end
    sys_old = m_sys;
    samp = m_s1; m_s1 = m_s0; m_s0 = int'(key_rst_n);
    // accept a new key level once the last DEB_CYC samples all disagree with it
    hist.push_back(samp);
    if (hist.size() > DEB_CYC) void'(hist.pop_front());
    if (hist.size() == DEB_CYC) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
      if (all_diff) m_deb = samp;
    end
    if (m_deb == 0) begin
      m_rel = 0; m_sys = 0;
    end else begin
      if (m_rel < 1000) m_rel++;
      m_sys = (m_rel >= RST_STRETCH + 1);
    end
    for (int c = 0; c < 3; c++) begin
      wr = cfg_we && (int'(cfg_ch) == c);
      if (!sys_old) begin
        m_pos[c] = 0; m_ce[c] = 0; m_sq[c] = 0; m_fired[c] = 0;
        m_per[c] = wr ? int'(cfg_div) : m_nxt[c];
      end else begin
        m_ce[c] = 0;
        if (run || step) begin
          m_pos[c]++;
          if (m_pos[c] >= ((m_per[c] == 0) ? 1 : m_per[c])) begin
            m_ce[c] = 1; m_sq[c] = !m_sq[c]; m_fired[c] = 1; m_pos[c] = 0;
            m_per[c] = wr ? int'(cfg_div) : m_nxt[c];
          end
        end
      end
      if (wr) m_nxt[c] = int'(cfg_div);
    end
    m_lock = m_sys && (&m_fired);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("ce", ce_o, m_ce);
    chk("sq", sq_o, m_sq);
    chk("sys", sys_reset_n_o, m_sys);
    chk("lock", locked_o, m_lock);
  endtask

  task automatic wait_ce(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ce_o[ch] && n < 300);
    if (!ce_o[ch]) chk("ce_seen", ce_o[ch], 1);
  endtask

  task automatic wait_sys(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sys_reset_n_o && n < 300);
    chk("rel_lat", (n >= REL_LAT - 1 && n <= REL_LAT + 1), 1);
  endtask

  task automatic check_align();
    int first [3];
    int lock_at;
    first = '{0, 0, 0};
    lock_at = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) if (ce_o[k] && first[k] == 0) first[k] = c;
      if (locked_o && lock_at == 0) lock_at = c;
      if (c == 12) chk("align_all", ce_o, 3'b111);
    end
    chk("first_ce0", first[0], 12);
    chk("first_ce1", first[1], 4);
    chk("first_ce2", first[2], 2);
    chk("lock_at", lock_at, 12);
  endtask

  initial begin
    int n, low_seen, snap, k_left;
    int cnt [3];

    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("rst_ce", ce_o, 0);
    chk("rst_sq", sq_o, 0);
    chk("rst_sys", sys_reset_n_o, 0);
    chk("rst_lock", locked_o, 0);

    reset_n = 1'b1;
    wait_sys(n);
    check_align();

    // short glitch on the key
    low_seen = 0;
    key_rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin cycle(); if (!sys_reset_n_o) low_seen = 1; end
    key_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin cycle(); if (!sys_reset_n_o) low_seen = 1; end
    chk("glitch_sys", low_seen, 0);

    // genuine press
    low_seen = 0;
    key_rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin cycle(); if (!sys_reset_n_o) low_seen = 1; end
    chk("press_low", low_seen, 1);
    key_rst_n = 1'b1;
    wait_sys(n);
    check_align();

    // ch1 := 7 written while its counter is 1
    wait_ce(1, n);
    cycle();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
    cycle();
    cfg_we = 1'b0;
    wait_ce(1, n); chk("mid_keep", n + 2, 4);
    wait_ce(1, n); chk("mid_new", n, 7);

    // write landing on the wrap cycle
    for (int i = 0; i < 6; i++) cycle();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    cycle();
    cfg_we = 1'b0;
    chk("wrap_ce", ce_o[1], 1);
    wait_ce(1, n); chk("wrap_new", n, 3);

    // zero ratio on ch2
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    cycle();
    cfg_we = 1'b0;
    wait_ce(2, n);
    for (int i = 0; i < 5; i++) begin cycle(); chk("div0_ce", ce_o[2], 1); end

    // reset mid-operation restores the initial ratios
    reset_n = 1'b0;
    cycle();
    chk("mrst_ce", ce_o, 0);
    chk("mrst_sys", sys_reset_n_o, 0);
    chk("mrst_lock", locked_o, 0);
    reset_n = 1'b1;
    wait_sys(n);
    check_align();

    // pause
    run = 1'b0;
    snap = int'(sq_o);
    n = 0;
    for (int i = 0; i < 100; i++) begin cycle(); if (ce_o != 0) n++; end
    chk("pause_ce", n, 0);
    chk("pause_sq", sq_o, snap);

    // single steps
    cnt = '{0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step = 1'b1; cycle();
      for (int k = 0; k < 3; k++) cnt[k] += int'(ce_o[k]);
      step = 1'b0; cycle();
      for (int k = 0; k < 3; k++) cnt[k] += int'(ce_o[k]);
    end
    chk("step_ce0", cnt[0], 1);
    chk("step_ce1", cnt[1], 3);
    chk("step_ce2", cnt[2], 6);

    // step has no effect while running
    run = 1'b1; step = 1'b1;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 48; i++) begin
      cycle();
      for (int k = 0; k < 3; k++) cnt[k] += int'(ce_o[k]);
    end
    step = 1'b0;
    chk("runstep_ce0", cnt[0], 4);
    chk("runstep_ce1", cnt[1], 12);
    chk("runstep_ce2", cnt[2], 24);

    // out-of-range channel select
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
    cycle();
    cfg_we = 1'b0;
    wait_ce(0, n); wait_ce(0, n); chk("badch_p0", n, 12);
    wait_ce(1, n); wait_ce(1, n); chk("badch_p1", n, 4);
    wait_ce(2, n); wait_ce(2, n); chk("badch_p2", n, 2);

    // randomized traffic against the model
    k_left = 0;
    for (int i = 0; i < 1500; i++) begin
      run     = ($urandom_range(0, 9) != 0);
      step    = ($urandom_range(0, 3) == 0);
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_div = 8'($urandom_range(0, 15));
      reset_n = ($urandom_range(0, 599) != 0);
      if (k_left > 0) begin
        key_rst_n = 1'b0; k_left--;
      end else begin
        key_rst_n = 1'b1;
        if ($urandom_range(0, 299) == 0) k_left = $urandom_range(5, 40);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
